gauss_pair_mult: RTL

GAUSS_PAIR_MULT -- requirements
Module: gauss_pair_mult

---
 rtl/gauss_pair_mult.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/gauss_pair_mult.sv
// gauss_pair_mult
// Final stage of a Box-Muller Gaussian generator. It multiplies the
// radius term f (Q4.12) by sin and by cos (Q0.16 magnitudes plus quadrant
// signs) and produces a pair of two's-complement Q4.11 samples.
//
// The upstream stages report completion with level-sticky done flags. Each
// flag is edge-detected. The operands are buffered in one pending slot per
// source, so a new pair can be collected while the previous pair waits on
// downstream backpressure.
//
// Output handshake (valid/ready):
//   out_valid rises together with the new gauss_x0/gauss_x1 values. While
//   out_valid=1, the data and out_valid stay stable until out_ready=1 is
//   seen on a rising edge. That edge is the transfer: out_valid drops,
//   sample_count increments and the block returns to IDLE. out_valid never
//   depends combinationally on out_ready.

module gauss_pair_mult #(
    parameter int ROUND_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sinAndCos_Done,
    input  logic [15:0] input_sin,
    input  logic [15:0] input_cos,
    input  logic        sin_neg,
    input  logic        cos_neg,
    input  logic        f_Done,
    input  logic [15:0] input_f,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] gauss_x0,
    output logic [15:0] gauss_x1,
    output logic        busy,
    output logic [15:0] sample_count,
    output logic        drop_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state;

    // Edge history is stored as "armed" bits: armed = the done input was low
    // on the previous cycle. Reset clears them. A done input that is already
    // high when reset is released therefore cannot look like a fresh edge. It
    // must fall and rise again.
    logic sc_armed;
    logic f_armed;

    // Pending operand slots, filled on done edges.
    logic        flag_sc;
    logic        flag_f;
    logic [15:0] op_sin;
    logic [15:0] op_cos;
    logic        op_sneg;
    logic        op_cneg;
    logic [15:0] op_f;

    // Working copies. These are frozen for the duration of one pair.
    logic [15:0] w_sin;
    logic [15:0] w_cos;
    logic        w_sneg;
    logic        w_cneg;
    logic [15:0] w_f;

    // Q4.28 products.
    logic [31:0] p0;
    logic [31:0] p1;

    // Control decode
    logic sc_edge;
    logic f_edge;
    logic start;
    logic sc_load;
    logic f_load;
    logic sc_drop;
    logic f_drop;
    logic handshake;

    // Rounding / sign datapath
    logic        rnd0;
    logic        rnd1;
    logic [15:0] m0;
    logic [15:0] m1;
    logic [15:0] x0_val;
    logic [15:0] x1_val;

    // Decode done edges and decide whether each edge is loaded or dropped.
    always_comb begin
        sc_edge   = sinAndCos_Done & sc_armed;
        f_edge    = f_Done & f_armed;
        start     = (state == S_IDLE) & flag_sc & flag_f;
        // A slot that is being emptied by start can accept a new operand on
        // the same edge. The old value moves to the working registers.
        sc_load   = sc_edge & enable & (~flag_sc | start);
        f_load    = f_edge  & enable & (~flag_f  | start);
        sc_drop   = sc_edge & enable & flag_sc & ~start;
        f_drop    = f_edge  & enable & flag_f  & ~start;
        handshake = (state == S_OUT) & out_valid & out_ready;
    end

    // Magnitude with optional round-half-up, then apply the sign.
    // The largest product 0xFFFE0001 gives m = 0x7FFF, so no saturation is needed.
    // Negating 0 yields 0, so -0 is never emitted.
    always_comb begin
        rnd0   = (ROUND_EN != 0) & p0[16];
        rnd1   = (ROUND_EN != 0) & p1[16];
        m0     = {1'b0, p0[31:17]} + {15'd0, rnd0};
        m1     = {1'b0, p1[31:17]} + {15'd0, rnd1};
        x0_val = w_sneg ? (16'd0 - m0) : m0;
        x1_val = w_cneg ? (16'd0 - m1) : m1;
    end

    // Track each done input's previous level. This keeps updating even with enable=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_armed <= 1'b0;
            f_armed  <= 1'b0;
        end else begin
            sc_armed <= ~sinAndCos_Done;
            f_armed  <= ~f_Done;
        end
    end

    // Pending operand slots, their flags and the sticky drop error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_sc  <= 1'b0;
            flag_f   <= 1'b0;
            op_sin   <= 16'd0;
            op_cos   <= 16'd0;
            op_sneg  <= 1'b0;
            op_cneg  <= 1'b0;
            op_f     <= 16'd0;
            drop_err <= 1'b0;
        end else begin
            if (sc_load) begin
                flag_sc <= 1'b1;
                op_sin  <= input_sin;
                op_cos  <= input_cos;
                op_sneg <= sin_neg;
                op_cneg <= cos_neg;
            end else if (start) begin
                flag_sc <= 1'b0;
            end

            if (f_load) begin
                flag_f <= 1'b1;
                op_f   <= input_f;
            end else if (start) begin
                flag_f <= 1'b0;
            end

            if (sc_drop || f_drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Main sequencer: IDLE -> MUL -> RND -> OUT -> IDLE, with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            w_sin        <= 16'd0;
            w_cos        <= 16'd0;
            w_sneg       <= 1'b0;
            w_cneg       <= 1'b0;
            w_f          <= 16'd0;
            p0           <= 32'd0;
            p1           <= 32'd0;
            out_valid    <= 1'b0;
            gauss_x0     <= 16'd0;
            gauss_x1     <= 16'd0;
            sample_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_sin  <= op_sin;
                        w_cos  <= op_cos;
                        w_sneg <= op_sneg;
                        w_cneg <= op_cneg;
                        w_f    <= op_f;
                        busy   <= 1'b1;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    p0    <= 32'(w_f) * 32'(w_sin);
                    p1    <= 32'(w_f) * 32'(w_cos);
                    state <= S_RND;
                end
                S_RND: begin
                    gauss_x0  <= x0_val;
                    gauss_x1  <= x1_val;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (handshake) begin
                        out_valid    <= 1'b0;
                        sample_count <= sample_count + 16'd1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
